// File: rtl/nand_gate_in_feeder.sv
// rtl/nand_gate_in_feeder.sv - operand FIFO feeding the a/b inputs of the NAND gate
//
// Buffers {a,b} operand pairs in a DEPTH-entry circular FIFO between an
// upstream valid/ready producer and the NAND gate's valid/ready consumer.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-low reset
//   flush      synchronous clear of all buffered pairs
//   in_valid   upstream offers in_a/in_b
//   in_ready   feeder accepts a pair this cycle
//   in_a/in_b  upstream operands
//   a/b        head operands to the gate (0 when empty)
//   out_valid  a/b carry a valid pair
//   out_ready  downstream consumes the head pair this cycle
//   count      occupancy, 0..DEPTH

module nand_gate_in_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [2*WIDTH-1:0] head;
    logic               push;
    logic               pop;

    // in_ready depends only on registered state and flush, so a full FIFO
    // never accepts in the same cycle it pops (no pass-through path).
    assign in_ready  = rst && !flush && (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign head = mem[rd_ptr];
    // Gate the head to zero when empty so stale or uninitialised storage
    // never reaches the NAND gate.
    assign a = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
    assign b = out_valid ? head[WIDTH-1:0]       : '0;

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
